// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, parity mode codes and frame-length helper.
// Used by the transmitter today and by the planned receiver and benches.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Wide enough to count up to 9 data bits or 2 stop bits.
  localparam int BIT_CNT_W = 4;

  function automatic int frame_len(input int cpb, input int data_bits,
                                   input int parity_mode, input int stop_bits);
    int par_bits;
    par_bits = (parity_mode != PAR_NONE) ? 1 : 0;
    return cpb * (1 + data_bits + par_bits + stop_bits);
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Valid/ready word handshake between a byte producer and the UART transmitter.
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses bit_tick_o on the last count.
// clear_i holds the count at zero so a new frame always starts on a fresh period.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic clear_i,
  output logic bit_tick_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_tick_o = !clear_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: accepts a word over valid/ready and shifts it out
// LSB-first with start bit, optional parity and 1-2 stop bits. All outputs registered.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_param_if.slave bus,
  output logic           tx,
  output logic           busy,
  output logic           parity_bit
);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_param: CLKS_PER_BIT must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be in 5..9");
  end
  if (PARITY_MODE < PAR_NONE || PARITY_MODE > PAR_ODD) begin : g_bad_parity
    $error("uart_tx_param: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);

  uart_state_e           state_q;
  logic [DATA_BITS-1:0]  shift_q;
  logic [BIT_CNT_W-1:0]  bit_cnt_q;
  logic                  tx_q;
  logic                  ready_q;
  logic                  busy_q;
  logic                  parity_q;
  logic                  bit_tick;
  logic                  baud_clear;

  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    case (PARITY_MODE)
      PAR_EVEN: return ^d;
      PAR_ODD:  return ~^d;
      default:  return 1'b0;
    endcase
  endfunction

  // The baud counter idles at zero so each start bit lasts a full period.
  assign baud_clear = !rst_n || (state_q == IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk       (clk),
    .clear_i   (baud_clear),
    .bit_tick_o(bit_tick)
  );

  assign tx           = tx_q;
  assign busy         = busy_q;
  assign parity_bit   = parity_q;
  assign bus.tx_ready = ready_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tx_q      <= 1'b1;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      parity_q  <= 1'b0;
      bit_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q      <= 1'b1;
          busy_q    <= 1'b0;
          ready_q   <= 1'b1;
          bit_cnt_q <= '0;
          if (bus.tx_valid && ready_q) begin
            shift_q  <= bus.tx_data;
            parity_q <= calc_parity(bus.tx_data);
            state_q  <= START;
            tx_q     <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        START: begin
          if (bit_tick) begin
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end
        end
        DATA: begin
          if (bit_tick) begin
            shift_q <= shift_q >> 1;
            if (bit_cnt_q == LAST_DATA) begin
              bit_cnt_q <= '0;
              if (PARITY_MODE != PAR_NONE) begin
                state_q <= PARITY;
                tx_q    <= parity_q;
              end else begin
                state_q <= STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              tx_q      <= shift_q[1];
            end
          end
        end
        PARITY: begin
          if (bit_tick) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
        end
        STOP: begin
          if (bit_tick) begin
            if (bit_cnt_q == LAST_STOP) begin
              state_q   <= IDLE;
              bit_cnt_q <= '0;
              ready_q   <= 1'b1;
              busy_q    <= 1'b0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four instances (8N1, 8E1, 8O1, 7N2) at 4 clocks per bit,
// each frame compared cycle by cycle against a bit list built from the frame rules.
module tb_uart_tx_param;

  localparam int CPB = 4;
  localparam int DBS[4] = '{8, 8, 8, 7};
  localparam int PMS[4] = '{0, 1, 2, 0};
  localparam int SBS[4] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data[4];
  logic       valid[4];
  logic       ready_w[4];
  logic       tx_w[4];
  logic       busy_w[4];
  logic       par_w[4];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 4; k++) begin : g_dut
    localparam int DB = DBS[k];
    uart_tx_param_if #(.DATA_BITS(DB)) bus ();
    assign bus.tx_data  = data[k][DB-1:0];
    assign bus.tx_valid = valid[k];
    assign ready_w[k]   = bus.tx_ready;

    uart_tx_param #(
      .CLKS_PER_BIT(CPB),
      .DATA_BITS   (DB),
      .PARITY_MODE (PMS[k]),
      .STOP_BITS   (SBS[k])
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .tx        (tx_w[k]),
      .busy      (busy_w[k]),
      .parity_bit(par_w[k])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for tx_ready, then presents the word so the next rising edge is the handshake.
  task automatic handshake(input int k, input logic [7:0] d);
    int n = 0;
    while (ready_w[k] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("ready_wait%0d", k), 32'(ready_w[k]), 32'd1);
    data[k]  = d;
    valid[k] = 1'b1;
    @(posedge clk);
  endtask

  // Called right after the handshake edge; checks the whole frame plus the idle cycle after it.
  task automatic run_frame(input int k, input logic [7:0] d, input bit hold, input logic [7:0] nxt);
    bit   q[$];
    int   ones = 0;
    logic par;
    int   flen;
    q.push_back(1'b0);
    for (int i = 0; i < DBS[k]; i++) begin
      q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (PMS[k] == 1) par = ones[0];
    else if (PMS[k] == 2) par = ~ones[0];
    else par = 1'b0;
    if (PMS[k] != 0) q.push_back(par);
    for (int i = 0; i < SBS[k]; i++) q.push_back(1'b1);
    flen = q.size() * CPB;
    chk($sformatf("frame_len%0d", k), 32'(uart_pkg::frame_len(CPB, DBS[k], PMS[k], SBS[k])),
        32'(flen));
    for (int c = 0; c < flen; c++) begin
      @(negedge clk);
      if (c == 0) begin
        valid[k] = hold;
        data[k]  = nxt;
        chk($sformatf("busy%0d", k), 32'(busy_w[k]), 32'd1);
        chk($sformatf("parity_bit%0d_%0h", k, d), 32'(par_w[k]), 32'(par));
      end
      chk($sformatf("ready_low%0d_c%0d", k, c), 32'(ready_w[k]), 32'd0);
      chk($sformatf("tx%0d_%0h_c%0d", k, d, c), 32'(tx_w[k]), 32'(q[c / CPB]));
    end
    @(negedge clk);
    chk($sformatf("idle_tx%0d", k), 32'(tx_w[k]), 32'd1);
    chk($sformatf("idle_ready%0d", k), 32'(ready_w[k]), 32'd1);
    chk($sformatf("idle_busy%0d", k), 32'(busy_w[k]), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      data[k]  = 8'h00;
      valid[k] = 1'b0;
    end
    valid[0] = 1'b1;

    // Reset held 5 cycles with tx_valid asserted
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_tx", 32'(tx_w[0]), 32'd1);
      chk("rst_ready", 32'(ready_w[0]), 32'd0);
      chk("rst_busy", 32'(busy_w[0]), 32'd0);
      chk("rst_par0", 32'(par_w[0]), 32'd0);
      chk("rst_par1", 32'(par_w[1]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", 32'(ready_w[0]), 32'd1);
    chk("rst_release_busy", 32'(busy_w[0]), 32'd0);
    valid[0] = 1'b0;

    // 8N1 0xA5
    handshake(0, 8'hA5);
    run_frame(0, 8'hA5, 1'b0, 8'h5A);

    // 8E1 / 8O1 with 0xA5 and 0x07
    handshake(1, 8'hA5);
    run_frame(1, 8'hA5, 1'b0, 8'hFF);
    handshake(1, 8'h07);
    run_frame(1, 8'h07, 1'b0, 8'h00);
    handshake(2, 8'hA5);
    run_frame(2, 8'hA5, 1'b0, 8'hFF);
    handshake(2, 8'h07);
    run_frame(2, 8'h07, 1'b0, 8'h00);

    // 7N2 0x7F
    handshake(3, 8'h7F);
    run_frame(3, 8'h7F, 1'b0, 8'h00);

    // Back-to-back with tx_valid held; data changes to the second word during frame one
    handshake(0, 8'h55);
    run_frame(0, 8'h55, 1'b1, 8'hAA);
    @(posedge clk);
    run_frame(0, 8'hAA, 1'b0, 8'h00);

    // Random words on every configuration
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) begin
        logic [7:0] d;
        d = 8'($urandom);
        handshake(k, d);
        run_frame(k, d, 1'b0, 8'($urandom));
      end
    end

    // Reset during data bit 3 (bit value 0 so the forced idle level is visible)
    handshake(0, 8'hF0);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      valid[0] = 1'b0;
    end
    chk("pre_abort_tx", 32'(tx_w[0]), 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_tx", 32'(tx_w[0]), 32'd1);
    chk("abort_busy", 32'(busy_w[0]), 32'd0);
    chk("abort_ready", 32'(ready_w[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_release_ready", 32'(ready_w[0]), 32'd1);
    handshake(0, 8'h3C);
    run_frame(0, 8'h3C, 1'b0, 8'hC3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter replacing the fixed 8-bit button/switch-driven transmitter. It accepts a data word over a valid/ready handshake and serialises it LSB-first onto a single line. Data width, parity mode, stop-bit count and baud divisor are set by parameters. It sits between any byte producer (switch capture logic, FIFO, CPU register) and the board's serial TX pin.

## Interface
- CLKS_PER_BIT, 868: clock cycles per serial bit (100 MHz / 115200); legal ≥ 2
- DATA_BITS, 8: data bits per frame; legal 5..9
- PARITY_MODE, 0: 0 none, 1 even, 2 odd
- STOP_BITS, 1: 1 or 2

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous reset, active-low
- tx_data  in  DATA_BITS  word to send, sampled on handshake
- tx_valid  in  1  producer has a word
- tx_ready  out  1  transmitter can accept a word this cycle
- tx  out  1  serial line, idle high
- busy  out  1  frame in progress
- parity_bit  out  1  parity of the last accepted word (0 when PARITY_MODE=0)

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1, tx_ready=1. On tx_valid && tx_ready: latch tx_data into shift register, compute parity, clear bit/baud counters, go to START.
- START: tx=0 for one bit period, then DATA.
- DATA: tx=shift[0]. At each bit-period end, shift right and increment bit counter. After DATA_BITS bits, go to PARITY if PARITY_MODE≠0, else STOP.
- PARITY: tx=parity_bit for one bit period. Even = XOR of data bits. Odd = inverted XOR.
- STOP: tx=1 for STOP_BITS bit periods, then IDLE.
- tx_ready is 0 in every state except IDLE. tx_valid outside IDLE is ignored, and tx_data is not sampled.
- busy = (state≠IDLE).
- parity_bit holds its value until the next accept.
- Reset (rst_n=0 at a clock edge, any state, including mid-frame): state=IDLE, tx=1, tx_ready=0, busy=0, parity_bit=0, counters=0. An aborted frame is not resumed.
- tx_ready rises in the first cycle after rst_n is sampled high.
- Illegal parameter values are rejected at elaboration.

## Timing
- Handshake at edge N: tx=0 (start bit) from cycle N+1.
- Every bit lasts exactly CLKS_PER_BIT cycles. Baud counter counts 0..CLKS_PER_BIT-1 and wraps; the bit ends at the wrap.
- Frame length F = CLKS_PER_BIT·(1+DATA_BITS+P+STOP_BITS), where P=1 if parity is enabled.
- tx_ready returns high at cycle N+1+F.
- Back-to-back words with tx_valid held high: the next handshake occurs at edge N+1+F, and its start bit begins at N+2+F. This gives exactly one idle-high cycle between frames.
- tx, tx_ready and busy are all registered outputs; there are no combinational paths from inputs to outputs.

## Structure
- Shared package uart_pkg:
  - state enum (IDLE/START/DATA/PARITY/STOP)
  - parity mode constants PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2
  - function for the frame-length calculation, reused by the future receiver and benches
- Sub-module uart_baud_gen:
  - counter with synchronous clear
  - emits a one-cycle bit_tick at the end of each period
  - parameter CLKS_PER_BIT
  - shared with the future uart_rx

## Test plan
- Reset: hold rst_n=0 for 5 cycles with tx_valid=1 -> tx=1, tx_ready=0, busy=0, parity_bit=0 throughout. tx_ready=1 one cycle after release.
- 8N1, CLKS_PER_BIT=4, send 0xA5 -> tx bit sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly 4 cycles. tx_ready high again 40 cycles after the start bit begins.
- 8E1 and 8O1, send 0xA5 -> parity bit 0 (even) / 1 (odd), placed after the data bits. Send 0x07 -> 1 / 0. parity_bit output matches in each case.
- 7N2, send 0x7F -> 0, seven 1s, then 2 stop bit periods of 1. Total frame 40 cycles at CLKS_PER_BIT=4.
- Back-to-back: tx_valid held with 0x55 then 0xAA -> exactly one idle-high cycle between frames. Changing tx_data during the first frame has no effect on it.
- Reset mid-frame: assert rst_n=0 during data bit 3 -> tx=1 at the next edge. After release, send 0x3C -> clean complete frame, no residue from the aborted frame.
